// File: rtl/fp_dlf_pkg.sv
// DLFloat16 format constants and result layout shared by the int-to-float converter.
package fp_dlf_pkg;

  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_BIAS  = 31;
  localparam int DLF_W     = 1 + DLF_EXP_W + DLF_MAN_W;

  // All-ones exponent with all-ones mantissa is reserved; the largest finite value sits one below it.
  localparam logic [DLF_W-1:0] DLF_NAN =
    {1'b0, {DLF_EXP_W{1'b1}}, {DLF_MAN_W{1'b1}}};
  localparam logic [DLF_W-1:0] DLF_MAX_FINITE =
    {1'b0, {DLF_EXP_W{1'b1}}, {(DLF_MAN_W-1){1'b1}}, 1'b0};

  typedef struct packed {
    logic                 sign;
    logic [DLF_EXP_W-1:0] exp;
    logic [DLF_MAN_W-1:0] man;
  } dlf_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W = 32,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] lz
);

  // Ascending scan: the highest set bit is the last to write, so it wins.
  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_vec[i]) lz = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_int2float_pipe.sv
// Three-stage integer to DLFloat converter: sign/magnitude, normalise, round/pack with saturation.
module fp_int2float_pipe
  import fp_dlf_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int BIAS  = DLF_BIAS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_W-1:0]         in_int,
  input  logic                     in_signed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     float_out,
  output logic                     out_inexact,
  output logic                     out_ovf
);

  localparam int FW  = 1 + EXP_W + MAN_W;
  localparam int EW  = EXP_W + 1;
  localparam int LZW = $clog2(INT_W + 1);
  localparam int XW  = INT_W + MAN_W + 2;
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  logic               s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
  logic [INT_W-1:0]   s1_mag_q, s1_mag_d;
  logic               s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic               s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d;
  logic [EW-1:0]      s2_e_q, s2_e_d;
  logic [MAN_W-1:0]   s2_man_q, s2_man_d;
  logic               s3_valid_q, s3_valid_d, s3_inexact_q, s3_inexact_d, s3_ovf_q, s3_ovf_d;
  logic [FW-1:0]      s3_float_q, s3_float_d;

  logic               s1_load, s2_load, s3_load;
  logic               neg;
  logic [LZW-1:0]     lz;
  logic [INT_W-1:0]   norm;
  logic [XW-1:0]      ext;
  logic               round_up, carry, sat;
  logic [MAN_W:0]     man_sum;
  logic [MAN_W-1:0]   man_r;
  logic [EW-1:0]      e_r, exp_full;

  fp_lzc #(.W(INT_W)) u_lzc (
    .in_vec (s1_mag_q),
    .lz     (lz)
  );

  // Each stage advances when empty or when the next stage takes its contents.
  always_comb begin
    s3_load  = !s3_valid_q || out_ready;
    s2_load  = !s2_valid_q || s3_load;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  always_comb begin
    neg        = in_signed & in_int[INT_W-1];
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_zero_d  = s1_zero_q;
    if (s1_load && in_valid) begin
      s1_sign_d = neg;
      s1_mag_d  = neg ? -in_int : in_int;
      s1_zero_d = (in_int == '0);
    end
  end

  always_comb begin
    norm        = s1_mag_q << lz;
    ext         = {norm, {(MAN_W + 2){1'b0}}};
    s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_e_d      = s2_e_q;
    s2_man_d    = s2_man_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    if (s2_load && s1_valid_q) begin
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = s1_zero_q;
      s2_e_d      = EW'(INT_W - 1) - EW'(lz);
      s2_man_d    = ext[XW-2 -: MAN_W];
      s2_guard_d  = ext[XW-2-MAN_W];
      s2_sticky_d = |ext[XW-3-MAN_W:0];
    end
  end

  // Exponent is carried one bit wider so overflow is visible before saturation.
  always_comb begin
    round_up     = s2_guard_q & (s2_sticky_q | s2_man_q[0]);
    man_sum      = {1'b0, s2_man_q} + (MAN_W + 1)'(round_up);
    carry        = man_sum[MAN_W];
    man_r        = carry ? '0 : man_sum[MAN_W-1:0];
    e_r          = s2_e_q + EW'(carry);
    exp_full     = e_r + EW'(BIAS);
    sat          = (exp_full > EXP_MAX) || ((exp_full == EXP_MAX) && (&man_r));
    s3_valid_d   = s3_load ? s2_valid_q : s3_valid_q;
    s3_float_d   = s3_float_q;
    s3_inexact_d = s3_inexact_q;
    s3_ovf_d     = s3_ovf_q;
    if (s3_load && s2_valid_q) begin
      if (s2_zero_q) begin
        s3_float_d   = '0;
        s3_inexact_d = 1'b0;
        s3_ovf_d     = 1'b0;
      end else if (sat) begin
        s3_float_d   = {s2_sign_q, {EXP_W{1'b1}}, {(MAN_W - 1){1'b1}}, 1'b0};
        s3_inexact_d = 1'b1;
        s3_ovf_d     = 1'b1;
      end else begin
        s3_float_d   = {s2_sign_q, exp_full[EXP_W-1:0], man_r};
        s3_inexact_d = s2_guard_q | s2_sticky_q;
        s3_ovf_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_mag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_guard_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
      s2_e_q       <= '0;
      s2_man_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_inexact_q <= 1'b0;
      s3_ovf_q     <= 1'b0;
      s3_float_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_zero_q    <= s1_zero_d;
      s1_mag_q     <= s1_mag_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_zero_q    <= s2_zero_d;
      s2_guard_q   <= s2_guard_d;
      s2_sticky_q  <= s2_sticky_d;
      s2_e_q       <= s2_e_d;
      s2_man_q     <= s2_man_d;
      s3_valid_q   <= s3_valid_d;
      s3_inexact_q <= s3_inexact_d;
      s3_ovf_q     <= s3_ovf_d;
      s3_float_q   <= s3_float_d;
    end
  end

  assign out_valid   = s3_valid_q;
  assign float_out   = s3_float_q;
  assign out_inexact = s3_inexact_q;
  assign out_ovf     = s3_ovf_q;

endmodule
